// File: rtl/rect_gen_pkg.sv
// Shared types and constants for the rectangle point generator.
package rect_gen_pkg;

  // Generator FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit positions inside the 2-bit mode operand.
  localparam int unsigned MODE_OUTLINE_BIT  = 0;
  localparam int unsigned MODE_COLMAJOR_BIT = 1;

endpackage

// File: rtl/raster_scan_counter.sv
// Inner/outer raster index pair. The inner index runs fastest; when
// skip_interior is set, interior outer lines visit only the first and last
// inner positions.
module raster_scan_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic             i_skip_interior,
  input  logic [WIDTH-1:0] i_inner_lim,
  input  logic [WIDTH-1:0] i_outer_lim,
  output logic [WIDTH-1:0] o_inner,
  output logic [WIDTH-1:0] o_outer,
  output logic             o_last
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] r_inner;
  logic [WIDTH-1:0] r_outer;
  logic [WIDTH-1:0] w_inner_max;
  logic [WIDTH-1:0] w_outer_max;
  logic             w_inner_end;
  logic             w_outer_end;
  logic             w_interior;

  // Limits are counts; the last valid index is one below.
  assign w_inner_max = i_inner_lim - One;
  assign w_outer_max = i_outer_lim - One;
  assign w_inner_end = (r_inner == w_inner_max);
  assign w_outer_end = (r_outer == w_outer_max);
  assign w_interior  = (r_outer != '0) && !w_outer_end;

  assign o_inner = r_inner;
  assign o_outer = r_outer;
  assign o_last  = w_inner_end && w_outer_end;

  // Step the index pair on each accepted point; clear restarts at the origin.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_clear) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_advance) begin
      if (w_inner_end) begin
        r_inner <= '0;
        r_outer <= r_outer + One;
      end else if (i_skip_interior && w_interior && (r_inner == '0)) begin
        // Interior line of an outline: jump straight to the far edge.
        r_inner <= w_inner_max;
      end else begin
        r_inner <= r_inner + One;
      end
    end
  end

endmodule

// File: rtl/rect_stream_gen.sv
// Streams the coordinates of an axis-aligned rectangle (filled or outline,
// row- or column-major) over a valid/ready handshake.
module rect_stream_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_s_x,
  input  logic [WIDTH-1:0] i_s_y,
  input  logic [WIDTH-1:0] i_width,
  input  logic [WIDTH-1:0] i_height,
  input  logic [1:0]       i_mode,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_out0,
  output logic [WIDTH-1:0] o_out1,
  output logic             o_valid,
  output logic             o_done
);

  import rect_gen_pkg::*;

  state_e           r_state;
  logic [WIDTH-1:0] r_sx;
  logic [WIDTH-1:0] r_sy;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_h;
  logic [1:0]       r_mode;
  logic             r_valid;
  logic             r_done;

  logic             w_colmajor;
  logic             w_outline;
  logic [WIDTH-1:0] w_inner_lim;
  logic [WIDTH-1:0] w_outer_lim;
  logic [WIDTH-1:0] w_inner;
  logic [WIDTH-1:0] w_outer;
  logic [WIDTH-1:0] w_col;
  logic [WIDTH-1:0] w_row;
  logic             w_last;
  logic             w_hs;
  logic             w_start_ok;
  logic             w_zero;

  assign w_colmajor  = r_mode[MODE_COLMAJOR_BIT];
  assign w_outline   = r_mode[MODE_OUTLINE_BIT];
  assign w_inner_lim = w_colmajor ? r_h : r_w;
  assign w_outer_lim = w_colmajor ? r_w : r_h;
  assign w_col       = w_colmajor ? w_outer : w_inner;
  assign w_row       = w_colmajor ? w_inner : w_outer;

  assign w_hs       = r_valid && i_ready;
  assign w_start_ok = i_start && (r_state != StRun);
  assign w_zero     = (i_width == '0) || (i_height == '0);

  // Coordinates are the latched origin plus the current index, mod 2^WIDTH.
  assign o_out0  = r_sx + w_col;
  assign o_out1  = r_sy + w_row;
  assign o_valid = r_valid;
  assign o_done  = r_done;

  // Index pair is frozen on the final point so outputs hold it in DONE.
  raster_scan_counter #(
    .WIDTH(WIDTH)
  ) u_scan (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_clear        (w_start_ok),
    .i_advance      (w_hs && !w_last),
    .i_skip_interior(w_outline),
    .i_inner_lim    (w_inner_lim),
    .i_outer_lim    (w_outer_lim),
    .o_inner        (w_inner),
    .o_outer        (w_outer),
    .o_last         (w_last)
  );

  // Control FSM: operand latch on start, valid/done sequencing.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_sx    <= '0;
      r_sy    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_mode  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_sx   <= i_s_x;
            r_sy   <= i_s_y;
            r_w    <= i_width;
            r_h    <= i_height;
            r_mode <= i_mode;
            if (w_zero) begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
              r_valid <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (w_hs && w_last) begin
            r_state <= StDone;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
